mmio_poll_initiator: RTL and testbench
======================================

// Module: mmio_poll_initiator
// PURPOSE
// - Bus initiator for the memory-mapped peripheral bus: drives address/readEnable/writeEnable/writeData and samples readData.
// - Periodically reads the switch register and, on change, writes the new value to the LED/7-seg register.
// - Logs each change into a data-memory ring buffer.
// - Sits in place of the CPU load/store path on the lab top for a standalone I/O demo.
// PARAMETERS
// - POLL_CYCLES  50_000        clk cycles between poll ticks; must be >= 8
// - DMEM_BASE    32'h0000_0000 byte address of log ring, word 0
// - LED_BASE     32'h0000_0200 LED/7-seg write register
// - SW_BASE      32'h0000_0300 switch read register
// - LOG_DEPTH    16            ring entries (32-bit words), power of two
// PORTS
// - clk          in   1   system clock
// - rst          in   1   reset: synchronous, active-high
// - enable       in   1   1 = polling active
// - address      out  32  bus byte address
// - readEnable   out  1   bus read strobe
// - writeEnable  out  1   bus write strobe
// - writeData    out  32  bus write data
// - readData     in   32  bus read data (from decoder read mux)
// - busy         out  1   FSM not in IDLE
// - change_count out  16  number of committed switch changes
// - log_ptr      out  $clog2(LOG_DEPTH)  next ring slot to write
// BEHAVIOUR
// - Reset values
//   - All outputs 0.
//   - last_sw=0, timer=0, FSM=IDLE.
// - Timer
//   - Counts 0..POLL_CYCLES-1 while enable=1; tick is a 1-cycle pulse at POLL_CYCLES-1, then wraps to 0.
//   - enable=0 clears the timer to 0.
//   - A tick is acted on only in IDLE; a tick while busy is dropped, not queued.
// - FSM: IDLE -> RD_REQ -> RD_WAIT -> {WR_LED -> WR_LOG} -> IDLE
//   - IDLE: bus idle (address=0, strobes=0). Goes to RD_REQ on tick&enable.
//   - RD_REQ: address=SW_BASE, readEnable=1.
//   - RD_WAIT: address=SW_BASE, readEnable=1; sample s=readData[15:0] at the end of this cycle.
//     - The 2-cycle read covers both combinational and 1-cycle registered responders.
//   - WR_LED is taken if s!=last_sw, otherwise the FSM returns to IDLE.
//   - WR_LED: address=LED_BASE, writeEnable=1, writeData={16'h0,s}; last_sw<=s.
//   - WR_LOG: address=DMEM_BASE+{log_ptr,2'b00}, writeEnable=1, writeData={change_count+1,s};
//     then change_count<=change_count+1 and log_ptr<=log_ptr+1.
// - Invariants and boundaries
//   - readEnable and writeEnable are never both 1.
//   - Every strobe lasts exactly 1 cycle, except the read strobe, which lasts 2.
//   - log_ptr wraps LOG_DEPTH-1 -> 0; change_count wraps 16'hFFFF -> 0.
//   - All bus outputs are registered; busy=1 in every state except IDLE.
//   - enable falling mid-sequence: the current sequence completes, then the FSM stays in IDLE.
//   - rst mid-sequence: the FSM returns to IDLE next cycle with strobes low, and any in-flight write is abandoned.
// CONFIGURATION
// - Macro POLL_DEBOUNCE_EN
//   - Defined: a change commits only if s equals the candidate captured at the previous poll and s!=last_sw.
//     Otherwise candidate<=s and the FSM returns to IDLE. A change therefore needs 2 consecutive identical polls.
//     candidate resets to 0.
//   - Undefined: a single differing sample commits immediately.
// STRUCTURE
// - Package mmio_map_pkg:
//   - FSM state encoding (3-bit).
//   - Default base-address constants shared with addressDecoder.
//   - Log-entry field layout {count[31:16], sw[15:0]}.
// - Sub-module poll_timer (POLL_CYCLES): enable/clear, tick output.
// - The FSM and datapath live in this module.
// TESTING (use POLL_CYCLES=8, LOG_DEPTH=4)
// 1. Reset, enable=1, switches=0: repeated polls, each with 2-cycle readEnable at SW_BASE.
//    Never writeEnable; change_count=0.
// 2. switches=16'h00A5: next poll writes 32'h000000A5 to LED_BASE, then 32'h000100A5 to DMEM_BASE+0.
//    log_ptr=1, busy low after 4 cycles.
// 3. Five distinct switch values over 5 polls: the fifth log write goes to DMEM_BASE+0 (wrap); change_count=5.
// 4. Drop enable during RD_WAIT: the sequence finishes (LED/log writes occur if changed), then no further strobes.
//    Re-enable: first tick after POLL_CYCLES cycles.
// 5. Assert rst during WR_LED: next cycle strobes=0, busy=0, change_count and log_ptr at 0.
// 6. POLL_DEBOUNCE_EN: switches 0->3 for one poll then back to 0 gives no write.
//    3 held for two polls gives a single LED write on the second poll.
// - Always assert: !(readEnable && writeEnable).

Source files
------------

// File: rtl/mmio_map_pkg.sv
// Shared memory-map constants, initiator FSM states and log-entry layout for the lab I/O bus.
package mmio_map_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_REQ  = 3'd1,
        ST_RD_WAIT = 3'd2,
        ST_WR_LED  = 3'd3,
        ST_WR_LOG  = 3'd4
    } poll_state_e;

    localparam logic [31:0] DMEM_BASE_DEF = 32'h0000_0000;
    localparam logic [31:0] LED_BASE_DEF  = 32'h0000_0200;
    localparam logic [31:0] SW_BASE_DEF   = 32'h0000_0300;

    typedef struct packed {
        logic [15:0] count;
        logic [15:0] sw;
    } log_entry_t;

    function automatic logic [31:0] make_log_entry(input logic [15:0] count,
                                                   input logic [15:0] sw);
        log_entry_t e;
        e.count = count;
        e.sw    = sw;
        return e;
    endfunction

endpackage

// File: rtl/mmio_poll_initiator_poll_timer.sv
// Free-running poll interval timer: one-cycle tick every POLL_CYCLES clocks while enabled.
module poll_timer #(
    parameter int unsigned POLL_CYCLES = 50_000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic enable_i,
    output logic tick_o
);

    localparam int unsigned CW = (POLL_CYCLES > 2) ? $clog2(POLL_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(POLL_CYCLES - 1);

    logic [CW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (!enable_i) begin
            count_d = '0;
        end else if (count_q == LAST) begin
            count_d = '0;
        end else begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tick_o = enable_i && (count_q == LAST);

endmodule

// File: rtl/mmio_poll_initiator.sv
// Switch-polling bus initiator: mirrors switch changes to the LED register and logs them to a DMEM ring.
// Optional macro POLL_DEBOUNCE_EN: commit a change only after two identical consecutive polls.
module mmio_poll_initiator
    import mmio_map_pkg::*;
#(
    parameter int unsigned POLL_CYCLES = 50_000,
    parameter logic [31:0] DMEM_BASE   = DMEM_BASE_DEF,
    parameter logic [31:0] LED_BASE    = LED_BASE_DEF,
    parameter logic [31:0] SW_BASE     = SW_BASE_DEF,
    parameter int unsigned LOG_DEPTH   = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    output logic [31:0]                  address,
    output logic                         readEnable,
    output logic                         writeEnable,
    output logic [31:0]                  writeData,
    input  logic [31:0]                  readData,
    output logic                         busy,
    output logic [15:0]                  change_count,
    output logic [$clog2(LOG_DEPTH)-1:0] log_ptr
);

    localparam int unsigned PW = $clog2(LOG_DEPTH);

    poll_state_e   state_q, state_d;
    logic [31:0]   address_q, address_d;
    logic          re_q, re_d;
    logic          we_q, we_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          busy_q, busy_d;
    logic [15:0]   last_sw_q, last_sw_d;
    logic [15:0]   s_q, s_d;
    logic [15:0]   count_q, count_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic          tick;
    logic          commit;
    logic          unused_rd_hi;
`ifdef POLL_DEBOUNCE_EN
    logic [15:0]   cand_q, cand_d;
`endif

    poll_timer #(
        .POLL_CYCLES(POLL_CYCLES)
    ) u_timer (
        .clk_i    (clk),
        .rst_i    (rst),
        .enable_i (enable),
        .tick_o   (tick)
    );

    assign unused_rd_hi = ^readData[31:16];

    always_comb begin
        state_d   = state_q;
        s_d       = s_q;
        last_sw_d = last_sw_q;
        count_d   = count_q;
        ptr_d     = ptr_q;
        commit    = 1'b0;
`ifdef POLL_DEBOUNCE_EN
        cand_d    = cand_q;
`endif
        unique case (state_q)
            ST_IDLE:    if (tick && enable) state_d = ST_RD_REQ;
            ST_RD_REQ:  state_d = ST_RD_WAIT;
            ST_RD_WAIT: begin
                s_d = readData[15:0];
`ifdef POLL_DEBOUNCE_EN
                commit = (readData[15:0] == cand_q) && (readData[15:0] != last_sw_q);
                cand_d = readData[15:0];
`else
                commit = (readData[15:0] != last_sw_q);
`endif
                state_d = commit ? ST_WR_LED : ST_IDLE;
            end
            ST_WR_LED: begin
                last_sw_d = s_q;
                state_d   = ST_WR_LOG;
            end
            ST_WR_LOG: begin
                count_d = count_q + 16'd1;
                ptr_d   = ptr_q + PW'(1);
                state_d = ST_IDLE;
            end
            default:    state_d = ST_IDLE;
        endcase
    end

    // Bus outputs are decoded from the next state so they register in step with state_q.
    always_comb begin
        address_d = '0;
        re_d      = 1'b0;
        we_d      = 1'b0;
        wdata_d   = '0;
        unique case (state_d)
            ST_RD_REQ, ST_RD_WAIT: begin
                address_d = SW_BASE;
                re_d      = 1'b1;
            end
            ST_WR_LED: begin
                address_d = LED_BASE;
                we_d      = 1'b1;
                wdata_d   = {16'h0000, s_d};
            end
            ST_WR_LOG: begin
                address_d = DMEM_BASE + {{(30 - PW){1'b0}}, ptr_q, 2'b00};
                we_d      = 1'b1;
                wdata_d   = make_log_entry(count_q + 16'd1, s_q);
            end
            default: ;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            address_q <= '0;
            re_q      <= 1'b0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            busy_q    <= 1'b0;
            last_sw_q <= '0;
            s_q       <= '0;
            count_q   <= '0;
            ptr_q     <= '0;
`ifdef POLL_DEBOUNCE_EN
            cand_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            address_q <= address_d;
            re_q      <= re_d;
            we_q      <= we_d;
            wdata_q   <= wdata_d;
            busy_q    <= busy_d;
            last_sw_q <= last_sw_d;
            s_q       <= s_d;
            count_q   <= count_d;
            ptr_q     <= ptr_d;
`ifdef POLL_DEBOUNCE_EN
            cand_q    <= cand_d;
`endif
        end
    end

    assign address      = address_q;
    assign readEnable   = re_q;
    assign writeEnable  = we_q;
    assign writeData    = wdata_q;
    assign busy         = busy_q;
    assign change_count = count_q;
    assign log_ptr      = ptr_q;

endmodule

// File: tb/tb_mmio_poll_initiator.sv
// Self-checking bench for mmio_poll_initiator using a transaction-queue model of the bus traffic.
module tb_mmio_poll_initiator;

    localparam int P = 8;
    localparam int D = 4;
    localparam logic [31:0] SWA  = 32'h0000_0300;
    localparam logic [31:0] LEDA = 32'h0000_0200;
`ifdef POLL_DEBOUNCE_EN
    localparam bit DEB = 1'b1;
`else
    localparam bit DEB = 1'b0;
`endif
    localparam int NPOLL = DEB ? 2 : 1;

    logic        clk, rst, enable;
    logic [31:0] address, writeData, readData;
    logic        readEnable, writeEnable, busy;
    logic [15:0] change_count;
    logic [1:0]  log_ptr;
    logic [15:0] sw;

    int checks = 0;
    int errors = 0;

    mmio_poll_initiator #(
        .POLL_CYCLES(P),
        .LOG_DEPTH(D)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .address(address), .readEnable(readEnable), .writeEnable(writeEnable),
        .writeData(writeData), .readData(readData), .busy(busy),
        .change_count(change_count), .log_ptr(log_ptr)
    );

    // Combinational responder; upper half is junk that the initiator must ignore.
    assign readData = (readEnable && address == SWA) ? {16'hBEEF, sw} : 32'hFFFF_FFFF;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        re;
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
        bit          rd2;
        bit          is_log;
    } beat_t;

    beat_t       q[$];
    beat_t       e, b;
    int          m_timer = 0;
    logic [15:0] m_last = '0, m_cand = '0, m_count = '0, s;
    int          m_ptr = 0;
    bit          cmt;

    int          n_we = 0, n_led = 0;
    logic [31:0] last_led = '0, last_log_addr = '0, last_log_data = '0;

    always @(negedge clk) begin
        if (q.size() != 0) e = q[0];
        else e = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0};
        chk("address", address, e.addr);
        chk("readEnable", {31'h0, readEnable}, {31'h0, e.re});
        chk("writeEnable", {31'h0, writeEnable}, {31'h0, e.we});
        chk("writeData", writeData, e.data);
        chk("busy", {31'h0, busy}, {31'h0, q.size() != 0});
        chk("change_count", {16'h0, change_count}, {16'h0, m_count});
        chk("log_ptr", {30'h0, log_ptr}, 32'(m_ptr));
        if (readEnable && writeEnable) chk("strobe_excl", 32'd1, 32'd0);
        if (writeEnable === 1'b1) begin
            n_we++;
            if (address == LEDA) begin
                n_led++;
                last_led = writeData;
            end else begin
                last_log_addr = address;
                last_log_data = writeData;
            end
        end
        if (rst) begin
            q.delete();
            m_timer = 0; m_last = '0; m_cand = '0; m_count = '0; m_ptr = 0;
        end else begin
            if (q.size() != 0) begin
                b = q.pop_front();
                if (b.rd2) begin
                    s   = sw;
                    cmt = DEB ? (s == m_cand && s != m_last) : (s != m_last);
                    m_cand = s;
                    if (cmt) begin
                        q.push_back('{1'b0, 1'b1, LEDA, {16'h0, s}, 1'b0, 1'b0});
                        q.push_back('{1'b0, 1'b1, 32'(m_ptr * 4), {m_count + 16'd1, s}, 1'b0, 1'b1});
                        m_last = s;
                    end
                end
                if (b.is_log) begin
                    m_count = m_count + 16'd1;
                    m_ptr   = (m_ptr + 1) % D;
                end
            end else if (enable && m_timer == P - 1) begin
                q.push_back('{1'b1, 1'b0, SWA, 32'h0, 1'b0, 1'b0});
                q.push_back('{1'b1, 1'b0, SWA, 32'h0, 1'b1, 1'b0});
            end
            m_timer = enable ? ((m_timer == P - 1) ? 0 : m_timer + 1) : 0;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    int  n, base_led;
    bit  found, prev_re;
    logic [15:0] vals[5] = '{16'h0011, 16'h0022, 16'h0033, 16'h0044, 16'h0055};

    initial begin
        rst = 1'b1; enable = 1'b0; sw = '0;
        step(3);
        chk("rst_address", address, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_count", {16'h0, change_count}, 32'h0);
        rst = 1'b0; enable = 1'b1;

        // 1: idle switches, reads only
        step(30);
        chk("t1_no_write", 32'(n_we), 32'd0);

        // 2: single change
        sw = 16'h00A5;
        step(P * (NPOLL + 1) + 2);
        chk("t2_led", last_led, 32'h0000_00A5);
        chk("t2_log_addr", last_log_addr, 32'h0);
        chk("t2_log_data", last_log_data, 32'h0001_00A5);
        chk("t2_ptr", {30'h0, log_ptr}, 32'd1);

        // 3: five changes wrap the ring
        rst = 1'b1; step(2); rst = 1'b0;
        foreach (vals[i]) begin
            sw = vals[i];
            step(P * (NPOLL + 1));
        end
        step(P);
        chk("t3_log_addr", last_log_addr, 32'h0);
        chk("t3_log_data", last_log_data, 32'h0005_0055);
        chk("t3_count", {16'h0, change_count}, 32'd5);
        chk("t3_ptr", {30'h0, log_ptr}, 32'd1);

        // 4: drop enable in RD_WAIT
        sw = 16'h0077; found = 1'b0; prev_re = readEnable;
        for (int k = 0; k < 20 && !found; k++) begin
            step(1);
            if (readEnable && !prev_re) found = 1'b1;
            prev_re = readEnable;
        end
        chk("t4_found_read", {31'h0, found}, 32'd1);
        step(1);
        enable = 1'b0;
        step(20);
        chk("t4_led", last_led, DEB ? 32'h0000_0055 : 32'h0000_0077);
        enable = 1'b1; n = 21;
        for (int k = 1; k <= 20; k++) begin
            step(1);
            if (readEnable) begin n = k; break; end
        end
        chk("t4_reenable_latency", 32'(n), 32'd8);
        step(20);

        // 5: reset during WR_LED
        sw = 16'h0099; found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            step(1);
            if (writeEnable && address == LEDA && writeData == 32'h99) found = 1'b1;
        end
        chk("t5_found_led", {31'h0, found}, 32'd1);
        rst = 1'b1;
        step(1);
        chk("t5_we", {31'h0, writeEnable}, 32'h0);
        chk("t5_busy", {31'h0, busy}, 32'h0);
        chk("t5_count", {16'h0, change_count}, 32'h0);
        chk("t5_ptr", {30'h0, log_ptr}, 32'h0);
        sw = '0;
        rst = 1'b0;
        step(20);

        // 6: one-poll glitch, then a held change
        found = 1'b0; prev_re = readEnable;
        for (int k = 0; k < 20 && !found; k++) begin
            step(1);
            if (readEnable && !prev_re) found = 1'b1;
            prev_re = readEnable;
        end
        chk("t6_found_read", {31'h0, found}, 32'd1);
        base_led = n_led;
        sw = 16'h0003;
        step(2);
        sw = 16'h0000;
        step(30);
        chk("t6_glitch_leds", 32'(n_led - base_led), DEB ? 32'd0 : 32'd2);
        base_led = n_led;
        sw = 16'h0003;
        step(P * 3);
        chk("t6_held_leds", 32'(n_led - base_led), 32'd1);
        chk("t6_led", last_led, 32'h0000_0003);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

endmodule
